// File: rtl/fifo_rd_packer.sv
// FIFO read-side packer: drains PACK data_size-bit words into one wide valid/ready word.
// Optional idle auto-flush is compiled in with `define RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int data_size = 8,
    parameter int PACK      = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                        rd_clk,
    input  logic                        rst,
    input  logic                        fifo_empty,
    input  logic [data_size-1:0]        fifo_data,
    output logic                        fifo_rd_en,
    input  logic                        flush,
    output logic [data_size*PACK-1:0]   m_data,
    output logic [PACK-1:0]             m_keep,
    output logic                        m_valid,
    input  logic                        m_ready
);
    localparam int            CW   = $clog2(PACK + 1);
    localparam logic [CW-1:0] FULL = CW'(PACK);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [PACK-1:0][data_size-1:0] r_acc;
    logic [CW-1:0]                  r_acc_cnt;
    logic                           r_inflight;
    logic                           r_flush_pend;

    logic                           w_free;
    logic                           w_full;
    logic                           w_part;
    logic                           w_load;
    logic                           w_flush_req;
    logic [CW:0]                    w_occ;
    logic [PACK-1:0]                w_keep;
    logic [PACK-1:0][data_size-1:0] w_word;

    assign w_free     = !m_valid || m_ready;
    assign w_occ      = {1'b0, r_acc_cnt} + {{CW{1'b0}}, r_inflight};
    assign fifo_rd_en = !rst && !fifo_empty && !r_flush_pend && (w_occ < {1'b0, FULL});

    // A word is complete either on the capture that fills the last lane or while parked at PACK.
    assign w_full = (r_inflight && (r_acc_cnt == LAST)) || (r_acc_cnt == FULL);
    assign w_part = r_flush_pend && !r_inflight && (r_acc_cnt != '0) && !w_full;
    assign w_load = (w_full || w_part) && w_free;

    always_comb begin
        for (int i = 0; i < PACK; i++) begin
            w_keep[i] = w_full || (CW'(i) < r_acc_cnt);
            w_word[i] = '0;
            if (w_keep[i])
                w_word[i] = (r_inflight && (r_acc_cnt == CW'(i))) ? fifo_data : r_acc[i];
        end
    end

`ifdef RD_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_to_cnt;
    logic          w_to_flush;

    assign w_to_flush  = (r_to_cnt == TW'(TIMEOUT));
    assign w_flush_req = flush || w_to_flush;

    always_ff @(posedge rd_clk) begin
        if (rst || r_inflight || (r_acc_cnt == '0) || w_to_flush)
            r_to_cnt <= '0;
        else if (fifo_empty)
            r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    assign w_flush_req = flush;
`endif

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_acc_cnt    <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_keep       <= '0;
        end else begin
            r_inflight <= fifo_rd_en;

            for (int i = 0; i < PACK; i++)
                if (r_inflight && (r_acc_cnt == CW'(i)))
                    r_acc[i] <= fifo_data;

            if (w_load)
                r_acc_cnt <= '0;
            else if (r_inflight)
                r_acc_cnt <= r_acc_cnt + 1'b1;

            // Any load leaves nothing behind, so it also retires a pending flush.
            if (w_load)
                r_flush_pend <= 1'b0;
            else if (w_flush_req && (w_occ != '0))
                r_flush_pend <= 1'b1;

            if (w_load) begin
                m_valid <= 1'b1;
                m_data  <= w_word;
                m_keep  <= w_keep;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed cases plus randomized traffic against a FIFO model
// and an in-order byte scoreboard.
module tb_fifo_rd_packer;
    localparam int DS = 8;
    localparam int PK = 4;
    localparam int TO = 16;

    logic            rd_clk = 1'b0;
    logic            rst;
    logic            fifo_empty = 1'b1;
    logic [DS-1:0]   fifo_data  = '0;
    logic            fifo_rd_en;
    logic            flush;
    logic [DS*PK-1:0] m_data;
    logic [PK-1:0]   m_keep;
    logic            m_valid;
    logic            m_ready;

    fifo_rd_packer #(.data_size(DS), .PACK(PK), .TIMEOUT(TO)) dut (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_keep(m_keep),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [DS-1:0] fifo_q[$];
    logic [DS-1:0] sb_q[$];

    // FIFO model: data appears the cycle after the read strobe.
    always @(posedge rd_clk) begin
        if (fifo_rd_en && fifo_q.size() != 0)
            fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    int              n_xfer = 0;
    logic            stall_d = 1'b0;
    logic [DS*PK-1:0] data_d = '0;
    logic [PK-1:0]   keep_d = '0;

    // Output monitor: handshake stability and in-order lane contents.
    always @(negedge rd_clk) begin
        int n;
        logic [DS-1:0] e;
        chk("rd_when_empty", fifo_rd_en & fifo_empty, 0);
        if (stall_d && !rst) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, data_d);
            chk("hold_keep", m_keep, keep_d);
        end
        if (!rst && m_valid && m_ready) begin
            n = 0;
            for (int i = 0; i < PK; i++) n += int'(m_keep[i]);
            chk("keep_nonzero", n != 0, 1);
            chk("keep_shape", m_keep, (64'd1 << n) - 64'd1);
            for (int i = 0; i < PK; i++) begin
                if (i < n) begin
                    chk("sb_avail", sb_q.size() != 0, 1);
                    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
                    chk("lane_data", m_data[DS*i +: DS], e);
                end else begin
                    chk("lane_zero", m_data[DS*i +: DS], 0);
                end
            end
            n_xfer++;
        end
        stall_d <= !rst && m_valid && !m_ready;
        data_d  <= m_data;
        keep_d  <= m_keep;
    end

    task automatic nxt();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [DS-1:0] d);
        fifo_q.push_back(d);
        sb_q.push_back(d);
    endtask

    // Returns at the negedge of the first cycle with fifo_rd_en high.
    task automatic wait_rd(output int ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) begin
                ok = 1;
                return;
            end
            nxt();
        end
    endtask

    task automatic wait_vld(input int lim, output int ok, output int k);
        ok = 0;
        k  = 0;
        for (int i = 1; i <= lim; i++) begin
            nxt();
            @(negedge rd_clk);
            if (m_valid) begin
                ok = 1;
                k  = i;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (n) nxt();
    endtask

    initial begin
        int ok, k, cnt, x0;
        rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
        repeat (3) nxt();
        @(negedge rd_clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data",  m_data, 0);
        chk("rst_keep",  m_keep, 0);
        nxt();
        rst = 1'b0;
        idle(2);

        // 1: four words, free-running sink
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_rd(ok);
        chk("t1_start", ok, 1);
        for (int kk = 1; kk <= 8; kk++) begin
            nxt();
            @(negedge rd_clk);
            chk("t1_rd_en", fifo_rd_en, kk < 4);
            chk("t1_valid", m_valid, kk == 5);
            if (kk == 5) begin
                chk("t1_data", m_data, 32'h44332211);
                chk("t1_keep", m_keep, 4'hF);
            end
        end
        idle(3);

        // 2: eight words with the sink stalled until cycle 12
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_rd(ok);
        chk("t2_start", ok, 1);
        for (int kk = 1; kk <= 15; kk++) begin
            nxt();
            if (kk == 12) m_ready = 1'b1;
            @(negedge rd_clk);
            if (kk == 5 || kk == 11 || kk == 12) begin
                chk("t2_held_valid", m_valid, 1);
                chk("t2_held_data", m_data, 32'h04030201);
            end
            if (kk == 10 || kk == 11) chk("t2_rd_blocked", fifo_rd_en, 0);
            if (kk == 13) begin
                chk("t2_w2_valid", m_valid, 1);
                chk("t2_w2_data", m_data, 32'h08070605);
                chk("t2_w2_keep", m_keep, 4'hF);
            end
            if (kk == 14) chk("t2_done", m_valid, 0);
        end
        idle(3);

        // 3: partial word via flush, then a flush with nothing accumulated
        push(8'hAA); push(8'hBB);
        wait_rd(ok);
        repeat (5) nxt();
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        wait_vld(10, ok, k);
        chk("t3_found", ok, 1);
        chk("t3_data", m_data, 32'h0000BBAA);
        chk("t3_keep", m_keep, 4'h3);
        idle(3);
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            nxt();
            @(negedge rd_clk);
            cnt += int'(m_valid);
        end
        chk("t3_empty_flush", cnt, 0);

        // 4: flush on the edge of the 4th capture
        x0 = n_xfer;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        wait_rd(ok);
        repeat (3) nxt();
        nxt(); flush = 1'b1;
        nxt(); flush = 1'b0;
        @(negedge rd_clk);
        chk("t4_valid", m_valid, 1);
        chk("t4_keep", m_keep, 4'hF);
        chk("t4_data", m_data, 32'hD4D3D2D1);
        repeat (12) nxt();
        chk("t4_one_word", n_xfer - x0, 1);

        // 5: reset with 3 captured and 1 in flight
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        wait_rd(ok);
        repeat (3) nxt();
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        @(negedge rd_clk);
        chk("t5_valid", m_valid, 0);
        chk("t5_data", m_data, 0);
        chk("t5_keep", m_keep, 0);
        chk("t5_rd_en", fifo_rd_en, 0);
        sb_q.delete();
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_vld(15, ok, k);
        chk("t5_found", ok, 1);
        chk("t5_data2", m_data, 32'hC4C3C2C1);
        chk("t5_keep2", m_keep, 4'hF);
        idle(3);

        // 6: single word left idle
        push(8'h5A);
        wait_rd(ok);
`ifdef RD_PACKER_TIMEOUT_EN
        wait_vld(TO + 20, ok, k);
        chk("t6_found", ok, 1);
        chk("t6_latency_ok", (k >= TO + 1) && (k <= TO + 6), 1);
        chk("t6_data", m_data, 32'h0000005A);
        chk("t6_keep", m_keep, 4'h1);
`else
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            nxt();
            @(negedge rd_clk);
            cnt += int'(m_valid);
        end
        chk("t6_no_auto_flush", cnt, 0);
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        wait_vld(10, ok, k);
        chk("t6_found", ok, 1);
        chk("t6_data", m_data, 32'h0000005A);
        chk("t6_keep", m_keep, 4'h1);
`endif
        idle(3);

        // randomized traffic, backpressure and flushes
        for (int i = 0; i < 3000; i++) begin
            nxt();
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16)
                push(8'($urandom_range(0, 255)));
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 19) == 0);
        end
        idle(30);
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        idle(30);
        chk("drain_sb", sb_q.size(), 0);
        chk("drain_fifo", fifo_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
